dffram_wb_adapter: RTL and testbench
====================================

// Module: dffram_wb_adapter
// PURPOSE
//  Wishbone classic (B4, non-pipelined) slave that drives one 256x32 DFFRAM macro port (CLK/WE0/EN0/A0/Di0/Do0).
//  Sits directly upstream of the RAM: decodes bus cycles, maps sel_i to byte write enables, times read data and acks.
//  Parent instantiates both this block and the RAM and connects the ram_* ports straight to the macro.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  byte base address of the RAM window; must be aligned to 2^(AW+2)
//  AW         8              RAM word-address width (window = 4*2^AW bytes)
// PORTS
//  CLK        in   1   single clock, shared with the RAM macro
//  RST        in   1   asynchronous, active-high reset
//  cyc_i      in   1   WB cycle
//  stb_i      in   1   WB strobe
//  we_i       in   1   WB write enable
//  sel_i      in   4   WB byte selects
//  adr_i      in   32  WB byte address
//  dat_i      in   32  WB write data
//  dat_o      out  32  WB read data
//  ack_o      out  1   WB acknowledge
//  ram_en     out  1   to EN0
//  ram_we     out  4   to WE0
//  ram_a      out  AW  to A0
//  ram_di     out  32  to Di0
//  ram_do     in   32  from Do0; valid the cycle after an enabled read edge
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, ack_o=0, dat_o=0. ram_en/ram_we are 0 in every state except IDLE-accept.
//  - hit = cyc_i & stb_i & (adr_i[31:AW+2] == BASE_ADDR[31:AW+2]).
//  - ram_a = adr_i[AW+1:2] and ram_di = dat_i, both combinational.
//  - FSM states: IDLE, RD, ACK.
//  - IDLE: on cyc_i&stb_i -> ram_en=hit; ram_we = (hit&we_i) ? sel_i : 4'h0.
//    Read hit -> RD (only when RDREG enabled, see CONFIGURATION), otherwise -> ACK.
//    Write or miss -> ACK.
//  - RD (RDREG only): ram_en=0; dat_o <= ram_do; -> ACK.
//  - ACK: ack_o=1 for exactly one cycle; -> IDLE unconditionally. ack_o is registered, never combinational.
//  - Read data: dat_o valid while ack_o=1.
//    Without RDREG: dat_o = ram_do (hit) or 0 (miss), muxed by a registered hit flag.
//    Writes: dat_o = 0.
//  - Latency stb->ack: write/miss 1 cycle; read 1 cycle (2 with RDREG). Back-to-back: stb held after ack restarts from IDLE,
//    so one idle cycle separates transactions (throughput 1 per 2 or 3 cycles).
//  - Miss (out-of-window address): no RAM access, writes dropped, read returns 32'h0, still acked (no err_o).
//  - sel_i=0 on write: acked, RAM untouched (ram_en=1, ram_we=0).
//  - Abort: cyc_i low while in RD -> return to IDLE, no ack. RAM already read, no side effect.
//    A write is committed at the accept edge and cannot be aborted.
//  - Reset mid-transaction: state to IDLE immediately, ack_o drops, a write already clocked stays in RAM.
//  - Address wrap: none; only adr_i[AW+1:2] reach the RAM. adr_i[1:0] ignored.
// CONFIGURATION
//  DFFRAM_WB_RDREG_EN defined:   reads pass through RD; dat_o is a flop fed from ram_do, 2-cycle read latency,
//                                RAM output removed from the bus timing path.
//  DFFRAM_WB_RDREG_EN undefined: RD state unreachable/omitted; dat_o combinational from ram_do, 1-cycle read latency.
// STRUCTURE
//  - Package dffram_pkg: state enum (IDLE/RD/ACK, 2-bit), DFFRAM_WSIZE=4, DFFRAM_DW=32.
//  - Single flat module; no sub-module (RAM macro lives in the parent).
// TESTING (bench: this block + behavioural 256x32 RAM model, BASE_ADDR=32'h3000_0000)
//  - Reset: RST=1 mid-read -> ack_o=0, dat_o=0, ram_en=0 same cycle; after release the next read completes normally.
//  - Write 0xDEADBEEF @0x3000_0010 sel=4'hF, then read @0x3000_0010 -> dat_o=0xDEADBEEF; acks 1 cycle after stb
//    (read 2 cycles with RDREG).
//  - Byte write sel=4'b0100 dat=0x00AA0000 @0x3000_0010 -> read returns 0xDEAABEEF.
//  - Miss: write 0x1234 @0x3000_0400 -> acked, ram_en stays 0; read @0x3000_0400 -> ack with dat_o=0.
//  - Top word @0x3000_03FC write/read 0xA5A5A5A5 -> ram_a=8'hFF, data matches; word 0 unchanged.
//  - RDREG build: drop cyc_i in RD -> no ack, FSM back to IDLE; a following write is acked in 1 cycle.

Source files
------------

// File: rtl/dffram_pkg.sv
// Shared types and constants for the DFFRAM Wishbone adapter.
// Also holds the sel_i to byte-write-enable mapping.
package dffram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        ACK  = 2'b10
    } state_t;

    localparam int DFFRAM_WSIZE = 4;
    localparam int DFFRAM_DW    = 32;

    // Byte write enables: only a write that hits the window may touch the RAM.
    function automatic logic [DFFRAM_WSIZE-1:0] byte_we(
        input logic                    hit,
        input logic                    we,
        input logic [DFFRAM_WSIZE-1:0] sel
    );
        if (hit && we) begin
            return sel;
        end else begin
            return {DFFRAM_WSIZE{1'b0}};
        end
    endfunction

endpackage

// File: rtl/dffram_wb_adapter.sv
// Wishbone classic slave driving one 256x32 DFFRAM port.
// Build option DFFRAM_WB_RDREG_EN adds a registered read stage (RD state).
module dffram_wb_adapter
    import dffram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [DFFRAM_WSIZE-1:0] sel_i,
    input  logic [31:0]             adr_i,
    input  logic [DFFRAM_DW-1:0]    dat_i,
    output logic [DFFRAM_DW-1:0]    dat_o,
    output logic                    ack_o,
    output logic                    ram_en,
    output logic [DFFRAM_WSIZE-1:0] ram_we,
    output logic [AW-1:0]           ram_a,
    output logic [DFFRAM_DW-1:0]    ram_di,
    input  logic [DFFRAM_DW-1:0]    ram_do
);

    state_t state_r;
    state_t next_s;
    logic   accept_s;
    logic   hit_s;
    logic   ack_r;
    logic   unused_s;

    assign accept_s = cyc_i & stb_i;
    assign hit_s    = accept_s & (adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign ram_a    = adr_i[AW+1:2];
    assign ram_di   = dat_i;
    assign ack_o    = ack_r;
    assign unused_s = ^adr_i[1:0];

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef DFFRAM_WB_RDREG_EN
                    if (hit_s && !we_i) begin
                        next_s = RD;
                    end else begin
                        next_s = ACK;
                    end
`else
                    next_s = ACK;
`endif
                end else begin
                    next_s = IDLE;
                end
            end
            RD: begin
`ifdef DFFRAM_WB_RDREG_EN
                // Dropping cyc_i here abandons the read without an ack.
                if (cyc_i) begin
                    next_s = ACK;
                end else begin
                    next_s = IDLE;
                end
`else
                next_s = IDLE;
`endif
            end
            ACK:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // RAM strobes: only asserted on the accept cycle in IDLE, and never under reset.
    always_comb begin
        ram_en = 1'b0;
        ram_we = {DFFRAM_WSIZE{1'b0}};
        if (!RST && (state_r == IDLE) && accept_s) begin
            ram_en = hit_s;
            ram_we = byte_we(hit_s, we_i, sel_i);
        end else begin
            ram_en = 1'b0;
            ram_we = {DFFRAM_WSIZE{1'b0}};
        end
    end

    // Registered acknowledge, high exactly while the FSM sits in ACK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= (next_s == ACK);
        end
    end

`ifdef DFFRAM_WB_RDREG_EN
    logic [DFFRAM_DW-1:0] dat_r;

    // Read data flop; zero outside a completed read so writes and misses return 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dat_r <= {DFFRAM_DW{1'b0}};
        end else if ((state_r == RD) && cyc_i) begin
            dat_r <= ram_do;
        end else begin
            dat_r <= {DFFRAM_DW{1'b0}};
        end
    end

    assign dat_o = dat_r;
`else
    logic rd_hit_r;

    // Flag set for the ACK cycle of a read hit; selects ram_do onto the bus.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_hit_r <= 1'b0;
        end else begin
            rd_hit_r <= (state_r == IDLE) & hit_s & ~we_i;
        end
    end

    assign dat_o = rd_hit_r ? ram_do : {DFFRAM_DW{1'b0}};
`endif

endmodule

// File: tb/tb_dffram_wb_adapter.sv
// Directed bench for dffram_wb_adapter with a behavioural 256x32 RAM model.
// Honours DFFRAM_WB_RDREG_EN for read latency and the abort scenario.
module tb_dffram_wb_adapter;

`ifdef DFFRAM_WB_RDREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] adr_i = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = 32'h0;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dffram_wb_adapter #(.BASE_ADDR(32'h3000_0000), .AW(8)) dut (
        .CLK(CLK), .RST(RST), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    // Behavioural DFFRAM: read-first, byte-masked write, Do0 valid the cycle after the edge.
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= mem[ram_a];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete bus transaction; returns ack latency and the RAM strobes seen at accept.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdat, output int lat,
                           output logic en_seen, output logic [3:0] we_seen, output logic [7:0] a_seen);
        @(negedge CLK);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        #1;
        en_seen = ram_en; we_seen = ram_we; a_seen = ram_a;
        lat = 0;
        rdat = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            lat++;
            if (ack_o) break;
        end
        if (!ack_o) lat = 99;
        rdat = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge CLK);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        en;
    logic [3:0]  wes;
    logic [7:0]  a;
    int          n;
    logic        any_ack;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_ack", {31'h0, ack_o}, 32'h0);
        check_eq("rst_dat", dat_o, 32'h0);
        check_eq("rst_en", {31'h0, ram_en}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        wb_xfer(1'b1, 32'h3000_0000, 4'hF, 32'h0BAD_F00D, rd, lat, en, wes, a);
        check_eq("w0_lat", lat, 32'd1);

        wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, rd, lat, en, wes, a);
        check_eq("w10_lat", lat, 32'd1);
        check_eq("w10_en", {31'h0, en}, 32'h1);
        check_eq("w10_we", {28'h0, wes}, 32'hF);
        check_eq("w10_a", {24'h0, a}, 32'h4);
        check_eq("w10_dat", rd, 32'h0);

        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("r10_lat", lat, RD_LAT);
        check_eq("r10_dat", rd, 32'hDEAD_BEEF);
        check_eq("r10_we", {28'h0, wes}, 32'h0);

        wb_xfer(1'b1, 32'h3000_0010, 4'b0100, 32'h00AA_0000, rd, lat, en, wes, a);
        check_eq("wb_we", {28'h0, wes}, 32'h4);
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("rb_dat", rd, 32'hDEAA_BEEF);

        wb_xfer(1'b1, 32'h3000_0400, 4'hF, 32'h0000_1234, rd, lat, en, wes, a);
        check_eq("wm_lat", lat, 32'd1);
        check_eq("wm_en", {31'h0, en}, 32'h0);
        check_eq("wm_we", {28'h0, wes}, 32'h0);
        wb_xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("rm_lat", lat, 32'd1);
        check_eq("rm_en", {31'h0, en}, 32'h0);
        check_eq("rm_dat", rd, 32'h0);

        wb_xfer(1'b1, 32'h3000_03FC, 4'hF, 32'hA5A5_A5A5, rd, lat, en, wes, a);
        check_eq("wtop_a", {24'h0, a}, 32'hFF);
        wb_xfer(1'b0, 32'h3000_03FC, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("rtop_dat", rd, 32'hA5A5_A5A5);
        wb_xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("r0_dat", rd, 32'h0BAD_F00D);

        wb_xfer(1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, rd, lat, en, wes, a);
        check_eq("wsel0_lat", lat, 32'd1);
        check_eq("wsel0_en", {31'h0, en}, 32'h1);
        check_eq("wsel0_we", {28'h0, wes}, 32'h0);
        wb_xfer(1'b0, 32'h3000_0013, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("rlow2_dat", rd, 32'hDEAA_BEEF);

        // Back-to-back: stb held across the ack restarts from IDLE.
        @(negedge CLK);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_03FC; sel_i = 4'hF;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (ack_o) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            n++;
            if (ack_o) break;
        end
        if (!ack_o) n = 99;
        check_eq("b2b_gap", n, RD_LAT + 1);
        check_eq("b2b_dat", dat_o, 32'hA5A5_A5A5);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge CLK);

        // Reset during a read.
        @(negedge CLK);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0010;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        check_eq("mrst_ack", {31'h0, ack_o}, 32'h0);
        check_eq("mrst_dat", dat_o, 32'h0);
        check_eq("mrst_en", {31'h0, ram_en}, 32'h0);
        @(negedge CLK);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("prst_lat", lat, RD_LAT);
        check_eq("prst_dat", rd, 32'hDEAA_BEEF);

`ifdef DFFRAM_WB_RDREG_EN
        // Abort in RD: no ack, then a write completes in one cycle.
        @(negedge CLK);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0010;
        @(posedge CLK); #1;
        any_ack = ack_o;
        cyc_i = 1'b0; stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            any_ack = any_ack | ack_o;
        end
        check_eq("abort_ack", {31'h0, any_ack}, 32'h0);
        wb_xfer(1'b1, 32'h3000_0014, 4'hF, 32'h5555_AAAA, rd, lat, en, wes, a);
        check_eq("abort_wlat", lat, 32'd1);
        wb_xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0, rd, lat, en, wes, a);
        check_eq("abort_rdat", rd, 32'h5555_AAAA);
`else
        any_ack = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
